id_issue_stage: RTL and testbench
=================================

ID_ISSUE_STAGE -- requirements
Module: id_issue_stage

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-high reset.
REQ-002 Parameter XLEN, default 32: immediate width (32 or 64).
REQ-003 Parameter NUM_REG, default 32: architectural GPR count (16 or 32).
REQ-004 clock  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 flush  in  1  kills slot contents; no pop that cycle.
REQ-007 queueValid  in  2  bit0 = insA present, bit1 = insB present (insA older).
REQ-008 insA, insB  in  32 each  next two RV32I instructions from the buffer.
REQ-009 pop  out  2  count consumed this cycle (0..2), combinational.
REQ-010 issueStall  in  1  downstream cannot accept slots.
REQ-011 wbValid  in  2  writeback ports 0/1 retiring a register.
REQ-012 wbRd0, wbRd1  in  5 each  retired destination indices.
REQ-013 slotValid  out  2  slot A (bit0) / slot B (bit1) hold an instruction.
REQ-014 slotIns  out  64  raw instructions {B, A}.
REQ-015 slotImm  out  2*XLEN  sign-extended immediates {B, A} per I/S/B/U/J format.
REQ-016 slotIllegal  out  2  illegal-instruction flags {B, A}.

Function
REQ-017 Decode-to-slot latency SHALL be one cycle (slots registered).
REQ-018 advance = !issueStall; when advance is 0, slots hold and pop = 0.
REQ-019 busy(r) = scoreboard bit r OR rd of a valid writing slot; x0 never busy; a register retired by wbValid this cycle counts as not busy.
REQ-020 A issues iff queueValid[0], advance, !flush and none of A's rs1, rs2, rd is busy.
REQ-021 B issues iff A issues, queueValid[1], B's rs1/rs2/rd are not busy and do not equal A's nonzero rd, A is not branch/JAL/JALR/SYSTEM/FENCE, not both load/store, and neither is illegal.
REQ-022 pop SHALL equal number issued; issued instructions load slots; non-issued slots load valid = 0 when advance is 1.
REQ-023 Scoreboard bit rd SHALL set when a valid, legal, register-writing slot is accepted (slotValid & !issueStall); set wins over a simultaneous wbValid clear of the same index.
REQ-024 wbValid[i] SHALL clear scoreboard bit wbRd[i]; both ports may clear in the same cycle.
REQ-025 Illegal = unknown opcode, or any used register index >= NUM_REG; illegal instructions issue alone in slot A with slotIllegal set and never set busy bits.
REQ-026 flush SHALL clear slotValid next cycle, force pop = 0, and leave scoreboard bits unchanged (killed slots never set bits).
REQ-027 queueValid = 2'b10 is invalid input; the block SHALL treat it as empty.

Reset
REQ-028 reset SHALL clear slotValid, slotIllegal, slotIns, slotImm and all scoreboard bits; pop = 0 while reset is high.
REQ-029 Reset mid-stall SHALL discard held slots without setting busy bits.

Configuration
REQ-030 Macro ID_DUAL_ISSUE_EN defined: behaviour per REQ-021; undefined: B never issues, slotValid[1] constantly 0, pop <= 1.

Structure
REQ-031 Shared package SHALL hold RV32I opcode constants, immediate-format enum and the register-index type.
REQ-032 One sub-module, id_decode, SHALL decode one instruction (fields, immediate, illegal, class); instantiated twice.

Verification
REQ-033 insA=ADDI x1,x0,5, insB=ADDI x2,x0,7, queueValid=11 -> pop=2, next cycle slotValid=11, slotImm A=5, B=7.
REQ-034 insA=ADDI x1,x0,1, insB=ADD x3,x1,x1 -> pop=1; B stalls while x1 busy; wbValid[0]=1, wbRd0=1 -> pop=1 that cycle.
REQ-035 issueStall=1 for 3 cycles with slotValid=11 -> pop=0, slots unchanged; release -> scoreboard sets both rds.
REQ-036 flush=1 with slotValid=01 (rd=x5) -> slotValid=00 next cycle, x5 not busy.
REQ-037 insA=0xFFFFFFFF -> pop=1, slotIllegal=01; NUM_REG=16 with ADD x17,x1,x2 -> slotIllegal=01.
REQ-038 Without ID_DUAL_ISSUE_EN, two independent ADDIs -> pop=1 per cycle, slotValid[1]=0.

Source files
------------

// File: rtl/id_issue_stage_pkg.sv
// Shared decode types for the ID/issue stage: RV32I opcodes, immediate formats,
// register index type and the per-instruction decode record.
package id_issue_stage_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} imm_fmt_e;

  typedef logic [4:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t rs1, rs2, rd;
    logic     use_rs1, use_rs2, wr_rd;
    logic     ctrl;     // branch/JAL/JALR/SYSTEM/FENCE: ends a dual-issue pair
    logic     mem;
    logic     illegal;
    imm_fmt_e fmt;
  } dec_t;

endpackage

// File: rtl/id_issue_stage_if.sv
// Instruction-queue, writeback and issue-slot signals of the ID/issue stage.
interface id_issue_stage_if #(parameter int XLEN = 32);
  logic              flush;
  logic [1:0]        queueValid;
  logic [31:0]       insA, insB;
  logic [1:0]        pop;
  logic              issueStall;
  logic [1:0]        wbValid;
  logic [4:0]        wbRd0, wbRd1;
  logic [1:0]        slotValid;
  logic [63:0]       slotIns;
  logic [2*XLEN-1:0] slotImm;
  logic [1:0]        slotIllegal;

  modport slave (
    input  flush, queueValid, insA, insB, issueStall, wbValid, wbRd0, wbRd1,
    output pop, slotValid, slotIns, slotImm, slotIllegal
  );

  modport master (
    output flush, queueValid, insA, insB, issueStall, wbValid, wbRd0, wbRd1,
    input  pop, slotValid, slotIns, slotImm, slotIllegal
  );
endinterface

// File: rtl/id_issue_stage_decode.sv
// id_decode: single-instruction RV32I decoder (register fields, class flags,
// sign-extended immediate, illegal detection against NUM_REG).
module id_decode
  import id_issue_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_REG = 32
) (
  input  logic [31:0]     ins_i,
  output dec_t            dec_o,
  output logic [XLEN-1:0] imm_o
);
  localparam logic [5:0] NREG = 6'(NUM_REG);

  dec_t        d;
  logic        known;
  logic [31:0] imm32;

  always_comb begin
    d       = '0;
    d.rs1   = ins_i[19:15];
    d.rs2   = ins_i[24:20];
    d.rd    = ins_i[11:7];
    d.fmt   = FMT_R;
    known   = 1'b1;
    case (ins_i[6:0])
      OPC_LUI, OPC_AUIPC: begin d.fmt = FMT_U; d.wr_rd = 1'b1; end
      OPC_JAL:    begin d.fmt = FMT_J; d.wr_rd = 1'b1; d.ctrl = 1'b1; end
      OPC_JALR:   begin d.fmt = FMT_I; d.use_rs1 = 1'b1; d.wr_rd = 1'b1; d.ctrl = 1'b1; end
      OPC_BRANCH: begin d.fmt = FMT_B; d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; d.ctrl = 1'b1; end
      OPC_LOAD:   begin d.fmt = FMT_I; d.use_rs1 = 1'b1; d.wr_rd = 1'b1; d.mem = 1'b1; end
      OPC_STORE:  begin d.fmt = FMT_S; d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; d.mem = 1'b1; end
      OPC_OPIMM:  begin d.fmt = FMT_I; d.use_rs1 = 1'b1; d.wr_rd = 1'b1; end
      OPC_OP:     begin d.fmt = FMT_R; d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; d.wr_rd = 1'b1; end
      OPC_FENCE, OPC_SYSTEM: begin d.fmt = FMT_I; d.ctrl = 1'b1; end
      default:    known = 1'b0;
    endcase
    d.illegal = !known
              | (d.use_rs1 && ({1'b0, d.rs1} >= NREG))
              | (d.use_rs2 && ({1'b0, d.rs2} >= NREG))
              | (d.wr_rd   && ({1'b0, d.rd}  >= NREG));
    // Illegal ops carry no register usage so they never stall or mark busy.
    if (d.illegal) begin
      d.use_rs1 = 1'b0;
      d.use_rs2 = 1'b0;
      d.wr_rd   = 1'b0;
    end
    case (d.fmt)
      FMT_I:   imm32 = {{20{ins_i[31]}}, ins_i[31:20]};
      FMT_S:   imm32 = {{20{ins_i[31]}}, ins_i[31:25], ins_i[11:7]};
      FMT_B:   imm32 = {{19{ins_i[31]}}, ins_i[31], ins_i[7], ins_i[30:25], ins_i[11:8], 1'b0};
      FMT_U:   imm32 = {ins_i[31:12], 12'b0};
      FMT_J:   imm32 = {{11{ins_i[31]}}, ins_i[31], ins_i[19:12], ins_i[20], ins_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    imm_o = XLEN'($signed(imm32));
    dec_o = d;
  end
endmodule

// File: rtl/id_issue_stage.sv
// ID/issue stage: decodes the two oldest queue entries, checks the scoreboard and
// loads up to two issue slots. Dual issue is enabled by defining ID_DUAL_ISSUE_EN.
module id_issue_stage
  import id_issue_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_REG = 32
) (
  input logic             clock,
  input logic             reset,
  id_issue_stage_if.slave io
);
  dec_t                    dec [2];
  logic [XLEN-1:0]         imm [2];
  logic [NUM_REG-1:0]      sb_q, sb_d;
  logic [31:0]             wb_clr, slot_hit, sb_set, busy;
  logic [1:0]              slot_vld_q, slot_vld_d, slot_ill_q, slot_ill_d;
  logic [1:0]              slot_wr_q, slot_wr_d, issue, accept;
  logic [1:0][4:0]         slot_rd_q, slot_rd_d;
  logic [63:0]             slot_ins_q, slot_ins_d;
  logic [2*XLEN-1:0]       slot_imm_q, slot_imm_d;
  logic                    advance, hz_a;

  id_decode #(.XLEN(XLEN), .NUM_REG(NUM_REG)) u_dec_a (.ins_i(io.insA), .dec_o(dec[0]), .imm_o(imm[0]));
  id_decode #(.XLEN(XLEN), .NUM_REG(NUM_REG)) u_dec_b (.ins_i(io.insB), .dec_o(dec[1]), .imm_o(imm[1]));

  assign advance = !io.issueStall;
  assign accept  = slot_vld_q & {2{advance & !io.flush}};

  // Writeback bypass only retires the scoreboard term; a slot still holding a
  // writer of the same register keeps it busy until that write is accepted.
  always_comb begin
    wb_clr   = '0;
    slot_hit = '0;
    sb_set   = '0;
    busy     = '0;
    for (int r = 1; r < NUM_REG; r++) begin
      wb_clr[r] = (io.wbValid[0] && io.wbRd0 == reg_idx_t'(r))
                | (io.wbValid[1] && io.wbRd1 == reg_idx_t'(r));
      for (int s = 0; s < 2; s++) begin
        if (slot_vld_q[s] && slot_wr_q[s] && slot_rd_q[s] == reg_idx_t'(r)) begin
          slot_hit[r] = 1'b1;
          if (accept[s]) sb_set[r] = 1'b1;
        end
      end
    end
    busy[NUM_REG-1:0] = (sb_q & ~wb_clr[NUM_REG-1:0]) | slot_hit[NUM_REG-1:0];
  end

  assign hz_a = (dec[0].use_rs1 & busy[dec[0].rs1])
              | (dec[0].use_rs2 & busy[dec[0].rs2])
              | (dec[0].wr_rd   & busy[dec[0].rd]);

  assign issue[0] = io.queueValid[0] & advance & !io.flush & !reset & !hz_a;

`ifdef ID_DUAL_ISSUE_EN
  logic hz_b, dep_b, a_wr;
  assign hz_b  = (dec[1].use_rs1 & busy[dec[1].rs1])
               | (dec[1].use_rs2 & busy[dec[1].rs2])
               | (dec[1].wr_rd   & busy[dec[1].rd]);
  assign a_wr  = dec[0].wr_rd & (dec[0].rd != '0);
  assign dep_b = a_wr & ((dec[1].use_rs1 & (dec[1].rs1 == dec[0].rd))
                       | (dec[1].use_rs2 & (dec[1].rs2 == dec[0].rd))
                       | (dec[1].wr_rd   & (dec[1].rd  == dec[0].rd)));
  assign issue[1] = issue[0] & io.queueValid[1] & !hz_b & !dep_b & !dec[0].ctrl
                  & !(dec[0].mem & dec[1].mem) & !dec[0].illegal & !dec[1].illegal;
`else
  assign issue[1] = 1'b0;
`endif

  assign io.pop = {issue[0] & issue[1], issue[0] ^ issue[1]};

  always_comb begin
    slot_vld_d = slot_vld_q;
    slot_ill_d = slot_ill_q;
    slot_ins_d = slot_ins_q;
    slot_imm_d = slot_imm_q;
    slot_rd_d  = slot_rd_q;
    slot_wr_d  = slot_wr_q;
    if (io.flush) begin
      slot_vld_d = '0;
      slot_ill_d = '0;
    end else if (advance) begin
      slot_vld_d = issue;
      slot_ill_d = issue & {dec[1].illegal, dec[0].illegal};
      slot_ins_d = {io.insB, io.insA};
      slot_imm_d = {imm[1], imm[0]};
      slot_rd_d  = {dec[1].rd, dec[0].rd};
      slot_wr_d  = {dec[1].wr_rd, dec[0].wr_rd};
    end
    sb_d = (sb_q & ~wb_clr[NUM_REG-1:0]) | sb_set[NUM_REG-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_vld_q <= '0;
      slot_ill_q <= '0;
      slot_ins_q <= '0;
      slot_imm_q <= '0;
      slot_rd_q  <= '0;
      slot_wr_q  <= '0;
      sb_q       <= '0;
    end else begin
      slot_vld_q <= slot_vld_d;
      slot_ill_q <= slot_ill_d;
      slot_ins_q <= slot_ins_d;
      slot_imm_q <= slot_imm_d;
      slot_rd_q  <= slot_rd_d;
      slot_wr_q  <= slot_wr_d;
      sb_q       <= sb_d;
    end
  end

  assign io.slotValid   = slot_vld_q;
  assign io.slotIllegal = slot_ill_q;
  assign io.slotIns     = slot_ins_q;
  assign io.slotImm     = slot_imm_q;
endmodule

// File: tb/tb_id_issue_stage.sv
// Directed bench for id_issue_stage; expectations adapt to ID_DUAL_ISSUE_EN.
module tb_id_issue_stage;
`ifdef ID_DUAL_ISSUE_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  localparam logic [31:0] ADDI_X1_5  = 32'h00500093;
  localparam logic [31:0] ADDI_X2_7  = 32'h00700113;
  localparam logic [31:0] ADDI_X1_1  = 32'h00100093;
  localparam logic [31:0] ADD_X3_X1  = 32'h001081B3;
  localparam logic [31:0] LUI_X4     = 32'h12345237;
  localparam logic [31:0] ADDI_X6_M1 = 32'hFFF00313;
  localparam logic [31:0] ADDI_X7_2  = 32'h00200393;
  localparam logic [31:0] ADD_X9_X4  = 32'h000204B3;
  localparam logic [31:0] ADD_X10_X6 = 32'h00030533;
  localparam logic [31:0] ADDI_X5_M1 = 32'hFFF00293;
  localparam logic [31:0] ADDI_X11_0 = 32'h00000593;
  localparam logic [31:0] ADDI_X13_0 = 32'h00000693;
  localparam logic [31:0] ADDI_X14_0 = 32'h00000713;
  localparam logic [31:0] ADDI_X15_0 = 32'h00000793;
  localparam logic [31:0] ADD_X16_15 = 32'h00078833;
  localparam logic [31:0] ADDI_X31_0 = 32'h00000F93;
  localparam logic [31:0] ADD_X17    = 32'h002088B3;
  localparam logic [31:0] BEQ_8      = 32'h00000463;

  logic clock = 1'b0;
  logic reset;
  int   n_run = 0, n_fail = 0;

  always #5 clock = ~clock;

  id_issue_stage_if #(.XLEN(32)) ifc ();
  id_issue_stage_if #(.XLEN(32)) ifc16 ();

  id_issue_stage #(.XLEN(32), .NUM_REG(32)) dut   (.clock(clock), .reset(reset), .io(ifc.slave));
  id_issue_stage #(.XLEN(32), .NUM_REG(16)) dut16 (.clock(clock), .reset(reset), .io(ifc16.slave));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drv(input logic [1:0] qv, input logic [31:0] a, input logic [31:0] b);
    ifc.queueValid = qv;
    ifc.insA       = a;
    ifc.insB       = b;
    #1;
  endtask

  task automatic wb(input logic [1:0] v, input logic [4:0] r0, input logic [4:0] r1);
    ifc.wbValid = v;
    ifc.wbRd0   = r0;
    ifc.wbRd1   = r1;
  endtask

  initial begin
    reset = 1'b1;
    ifc.flush = 0; ifc.issueStall = 0; wb(2'b00, 0, 0);
    ifc16.flush = 0; ifc16.issueStall = 0; ifc16.wbValid = 0; ifc16.wbRd0 = 0; ifc16.wbRd1 = 0;
    ifc16.queueValid = 0; ifc16.insA = 0; ifc16.insB = 0;
    drv(2'b01, ADDI_X1_5, 32'h0);
    tick(); tick();
    chk("rst_pop", 64'(ifc.pop), 64'd0);
    chk("rst_vld", 64'(ifc.slotValid), 64'd0);
    chk("rst_ill", 64'(ifc.slotIllegal), 64'd0);
    chk("rst_ins", ifc.slotIns, 64'd0);
    chk("rst_imm", ifc.slotImm, 64'd0);
    reset = 1'b0;

    // two independent ADDIs
    drv(2'b11, ADDI_X1_5, ADDI_X2_7);
    chk("pair_pop", 64'(ifc.pop), DUAL ? 64'd2 : 64'd1);
    tick();
    drv(2'b00, 32'h0, 32'h0);
    chk("pair_vld", 64'(ifc.slotValid), DUAL ? 64'd3 : 64'd1);
    chk("pair_immA", 64'(ifc.slotImm[31:0]), 64'd5);
    chk("pair_immB", 64'(ifc.slotImm[63:32]), 64'd7);
    tick();
    wb(2'b11, 5'd1, 5'd2);
    tick();
    wb(2'b00, 0, 0);

    // RAW dependency on x1, released by writeback bypass
    drv(2'b11, ADDI_X1_1, ADD_X3_X1);
    chk("raw_pop", 64'(ifc.pop), 64'd1);
    tick();
    drv(2'b01, ADD_X3_X1, 32'h0);
    chk("raw_slot_busy", 64'(ifc.pop), 64'd0);
    tick();
    chk("raw_sb_busy", 64'(ifc.pop), 64'd0);
    tick();
    wb(2'b01, 5'd1, 5'd0); #1;
    chk("raw_wb_bypass", 64'(ifc.pop), 64'd1);
    tick();
    wb(2'b00, 0, 0);
    drv(2'b00, 32'h0, 32'h0);
    chk("raw_vld", 64'(ifc.slotValid), 64'd1);
    chk("raw_ins", 64'(ifc.slotIns[31:0]), 64'(ADD_X3_X1));
    tick();

    // stall for three cycles with slots held
    wb(2'b01, 5'd3, 5'd0);
    drv(2'b11, LUI_X4, ADDI_X6_M1);
    chk("stl_pop0", 64'(ifc.pop), DUAL ? 64'd2 : 64'd1);
    tick();
    wb(2'b00, 0, 0);
    ifc.issueStall = 1'b1;
    drv(2'b01, ADDI_X7_2, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("stl_pop", 64'(ifc.pop), 64'd0);
      chk("stl_vld", 64'(ifc.slotValid), DUAL ? 64'd3 : 64'd1);
      chk("stl_immA", 64'(ifc.slotImm[31:0]), 64'h12345000);
      if (i < 2) tick();
    end
    ifc.issueStall = 1'b0;
    wb(2'b01, 5'd4, 5'd0); #1;
    chk("stl_release_pop", 64'(ifc.pop), 64'd1);
    tick();
    wb(2'b00, 0, 0);
    drv(2'b01, ADD_X9_X4, 32'h0);
    chk("sb_set_wins_x4", 64'(ifc.pop), 64'd0);
    drv(2'b01, ADD_X10_X6, 32'h0);
    chk("sb_x6", 64'(ifc.pop), DUAL ? 64'd0 : 64'd1);
    drv(2'b00, 32'h0, 32'h0);
    tick();
    wb(2'b11, 5'd4, 5'd6);
    tick();
    wb(2'b01, 5'd7, 5'd0);
    tick();
    wb(2'b00, 0, 0);

    // flush kills slot A holding x5
    drv(2'b01, ADDI_X5_M1, 32'h0);
    chk("fl_pop_pre", 64'(ifc.pop), 64'd1);
    tick();
    ifc.flush = 1'b1;
    drv(2'b01, ADDI_X11_0, 32'h0);
    chk("fl_pop", 64'(ifc.pop), 64'd0);
    chk("fl_vld_pre", 64'(ifc.slotValid), 64'd1);
    chk("fl_immA_neg", 64'(ifc.slotImm[31:0]), 64'hFFFFFFFF);
    tick();
    ifc.flush = 1'b0;
    drv(2'b01, ADDI_X5_M1, 32'h0);
    chk("fl_vld", 64'(ifc.slotValid), 64'd0);
    chk("fl_x5_free", 64'(ifc.pop), 64'd1);
    drv(2'b00, 32'h0, 32'h0);
    tick();

    // illegal opcode, and out-of-range register on the 16-GPR instance
    ifc16.queueValid = 2'b01;
    ifc16.insA = ADD_X17;
    drv(2'b11, 32'hFFFFFFFF, ADDI_X13_0);
    chk("ill_pop", 64'(ifc.pop), 64'd1);
    chk("ill16_pop", 64'(ifc16.pop), 64'd1);
    tick();
    ifc16.queueValid = 2'b00;
    drv(2'b00, 32'h0, 32'h0);
    chk("ill_flag", 64'(ifc.slotIllegal), 64'd1);
    chk("ill_vld", 64'(ifc.slotValid), 64'd1);
    chk("ill16_flag", 64'(ifc16.slotIllegal), 64'd1);
    drv(2'b01, ADDI_X31_0, 32'h0);
    chk("ill_no_busy", 64'(ifc.pop), 64'd1);
    drv(2'b00, 32'h0, 32'h0);
    tick();

    // queueValid=10 is empty; branch in A ends the pair
    drv(2'b10, ADDI_X14_0, ADDI_X14_0);
    chk("qv10_pop", 64'(ifc.pop), 64'd0);
    drv(2'b11, BEQ_8, ADDI_X14_0);
    chk("br_pop", 64'(ifc.pop), 64'd1);
    tick();
    drv(2'b00, 32'h0, 32'h0);
    chk("br_vld", 64'(ifc.slotValid), 64'd1);
    chk("br_imm", 64'(ifc.slotImm[31:0]), 64'd8);
    tick();

    // reset while stalled discards the held slot without marking x15
    drv(2'b01, ADDI_X15_0, 32'h0);
    tick();
    ifc.issueStall = 1'b1;
    drv(2'b00, 32'h0, 32'h0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ifc.issueStall = 1'b0;
    drv(2'b01, ADD_X16_15, 32'h0);
    chk("rst_stl_vld", 64'(ifc.slotValid), 64'd0);
    chk("rst_stl_ins", ifc.slotIns, 64'd0);
    chk("rst_stl_x15", 64'(ifc.pop), 64'd1);
    drv(2'b00, 32'h0, 32'h0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
